cordic_vectoring_arbiter: RTL

Shares one `CORDIC_Vectoring` pipeline (8 stages plus output register, no stall, no valid) between `N_REQ` requesters. Grants round-robin, presents the winner's vector to the datapath, and carries a requester-id/valid tag pipeline matched to the datapath latency. Buffers finished results in a credit-protected response FIFO with a valid/ready output. Sits between requester logic and the CORDIC datapath; results never drop and never reorder.

---
 rtl/cordic_arb_pkg.sv | 16 +
 rtl/cordic_resp_fifo.sv | 87 ++++++++
 rtl/cordic_resp_fifo_chk.sv | 20 ++
 rtl/cordic_vectoring_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/cordic_arb_pkg.sv
// Shared defaults and types for the CORDIC vectoring arbiter slice.
package cordic_arb_pkg;

   localparam int DEF_N_REQ      = 4;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_LATENCY    = 9;
   localparam int DEF_FIFO_DEPTH = 10;
   localparam int ID_W           = $clog2(DEF_N_REQ);

   typedef struct packed {
      logic [ID_W-1:0]       id;
      logic [DEF_DATA_W-1:0] norm;
      logic [DEF_DATA_W-1:0] angle;
   } resp_t;

endpackage

// File: rtl/cordic_resp_fifo.sv
// Circular response buffer with registered empty/count; head is read combinationally.
module cordic_resp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 10
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             empty_r;
   logic             full_r;
   logic             do_push_s;
   logic             do_pop_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop_s  = pop & ~empty_r;
   assign do_push_s = push & (~full_r | do_pop_s);

   // Storage needs no reset: the head is masked while empty
   always_ff @(posedge clock) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers, occupancy and flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         case ({do_push_s, do_pop_s})
            2'b10: begin
               count_r <= count_r + CNT_W'(1);
               empty_r <= 1'b0;
               full_r  <= (count_r == CNT_W'(DEPTH - 1));
            end
            2'b01: begin
               count_r <= count_r - CNT_W'(1);
               empty_r <= (count_r == CNT_W'(1));
               full_r  <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign head  = empty_r ? '0 : mem_r[rd_ptr_r];
   assign empty = empty_r;
   assign count = count_r;

   cordic_resp_fifo_chk u_chk (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .full    (full_r),
      .empty   (empty_r)
   );

endmodule

// File: rtl/cordic_resp_fifo_chk.sv
// Protocol checker for the response FIFO: no write into a full buffer, no read of an empty one.
module cordic_resp_fifo_chk (
   input logic clock,
   input logic reset_n,
   input logic push,
   input logic pop,
   input logic full,
   input logic empty
);

   // Sample FIFO handshakes once per clock while out of reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
      end else begin
         assert (!(push && full));
         assert (!(pop && empty));
      end
   end

endmodule

// File: rtl/cordic_vectoring_arbiter.sv
// Round-robin front end sharing one fixed-latency CORDIC vectoring pipeline,
// with a latency-matched id tag pipeline and a credit-protected response FIFO.
module cordic_vectoring_arbiter
   import cordic_arb_pkg::*;
#(
   parameter int N_REQ      = DEF_N_REQ,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LATENCY    = DEF_LATENCY,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*DATA_W-1:0]    req_x,
   input  logic [N_REQ*DATA_W-1:0]    req_y,
   output logic [DATA_W-1:0]          cordic_x,
   output logic [DATA_W-1:0]          cordic_y,
   output logic                       cordic_reset,
   input  logic [DATA_W-1:0]          cordic_norm,
   input  logic [DATA_W-1:0]          cordic_angle,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [$clog2(N_REQ)-1:0]   resp_id,
   output logic [DATA_W-1:0]          resp_norm,
   output logic [DATA_W-1:0]          resp_angle
);

   localparam int IDW   = $clog2(N_REQ);
   localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
   localparam int CNT_W = FC_W + 1;
   localparam int ENT_W = IDW + 2 * DATA_W;

   logic [IDW-1:0]                rr_ptr_r;
   logic [IDW-1:0]                grant_id_s;
   logic [IDW-1:0]                cand_s;
   logic                          grant_vld_s;
   logic                          hit_s;
   logic                          can_issue_s;
   logic                          handshake_s;
   logic [LATENCY-1:0]            tag_vld_r;
   logic [LATENCY-1:0][IDW-1:0]   tag_id_r;
   logic [FC_W-1:0]               inflight_r;
   logic [FC_W-1:0]               fifo_count_s;
   logic                          fifo_empty_s;
   logic                          pop_s;
   logic [ENT_W-1:0]              push_data_s;
   logic [ENT_W-1:0]              head_s;

   // Both counts are registered, so a pop only frees its credit on the following cycle
   assign can_issue_s = reset_n &
                        ((CNT_W'(inflight_r) + CNT_W'(fifo_count_s)) < CNT_W'(FIFO_DEPTH));

   // First requester at or after rr_ptr, searching upward with wrap
   always_comb begin
      grant_vld_s = 1'b0;
      grant_id_s  = rr_ptr_r;
      cand_s      = '0;
      hit_s       = 1'b0;
      for (int off = 0; off < N_REQ; off++) begin
         cand_s      = IDW'((int'(rr_ptr_r) + off) % N_REQ);
         hit_s       = ~grant_vld_s & req_valid[cand_s];
         grant_id_s  = hit_s ? cand_s : grant_id_s;
         grant_vld_s = grant_vld_s | hit_s;
      end
   end

   assign handshake_s = can_issue_s & grant_vld_s;

   // One-hot grant to the selected requester
   always_comb begin
      req_ready = '0;
      if (handshake_s) begin
         req_ready[grant_id_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   assign cordic_x     = handshake_s ? req_x[grant_id_s*DATA_W +: DATA_W] : '0;
   assign cordic_y     = handshake_s ? req_y[grant_id_s*DATA_W +: DATA_W] : '0;
   assign cordic_reset = ~reset_n;

   // Pointer advance, tag shift aligned with datapath capture, in-flight tally
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_r   <= '0;
         tag_vld_r  <= '0;
         tag_id_r   <= '0;
         inflight_r <= '0;
      end else begin
         if (handshake_s) begin
            rr_ptr_r <= (grant_id_s == IDW'(N_REQ - 1)) ? '0 : grant_id_s + IDW'(1);
         end
         tag_vld_r  <= {tag_vld_r[LATENCY-2:0], handshake_s};
         tag_id_r   <= {tag_id_r[LATENCY-2:0], grant_id_s};
         inflight_r <= inflight_r + FC_W'(handshake_s) - FC_W'(tag_vld_r[LATENCY-1]);
      end
   end

   assign push_data_s = {tag_id_r[LATENCY-1], cordic_norm, cordic_angle};
   assign pop_s       = ~fifo_empty_s & resp_ready;

   cordic_resp_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (tag_vld_r[LATENCY-1]),
      .push_data (push_data_s),
      .pop       (pop_s),
      .head      (head_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   assign resp_valid = ~fifo_empty_s;
   assign {resp_id, resp_norm, resp_angle} = head_s;

endmodule
